fillq_bank: RTL and testbench
=============================

# fillq_bank

Parametrised fill queue holding `NUM_ENTRIES` outstanding cache-line fills between the mem pipe (allocation at mm5, fill pass issued at mm0) and the memory interface. It generalises the single-entry fill FSM into a bank with several additions:
- lowest-free allocation
- round-robin mem and pipe arbitration with request stability
- programmable recycle backoff
- optional same-line merge of secondary misses

## Interface
Parameters:
- `NUM_ENTRIES`, 4: fill entries; ≥2.
- `PADDR_W`, 40: physical address width.
- `LINE_BITS`, 6: line offset bits ignored for merge compare.
- `RECYCLE_DLY`, 3: extra backoff cycles after recycle; width 4 bits.
- `ID_W`, $clog2(NUM_ENTRIES): entry id width (derived, do not override).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `alloc_valid_mm5`  in  1  fill allocation request.
- `alloc_paddr_mm5`  in  PADDR_W  miss address.
- `alloc_id_mm5`  out  ID_W  entry allocated or merged into (combinational).
- `alloc_merged_mm5`  out  1  request merged into existing entry (combinational).
- `full`  out  1  no idle entry.
- `num_valid`  out  ID_W+1  count of non-idle entries.
- `mem_req_valid`  out  1  memory request.
- `mem_req_id`  out  ID_W  requesting entry.
- `mem_req_addr`  out  PADDR_W  its paddr.
- `mem_gnt`  in  1  memory accepts current request.
- `mem_rsp_valid`  in  1  fill data returned.
- `mem_rsp_id`  in  ID_W  entry the response targets.
- `pipe_req_mm0`  out  1  fill pass request to pipe arbiter.
- `pipe_req_id_mm0`  out  ID_W  requesting entry.
- `pipe_req_addr_mm0`  out  PADDR_W  its paddr.
- `pipe_gnt_mm0`  in  1  pipe grant.
- `pipe_valid_mm5`  in  1  mm5 action valid.
- `pipe_is_fill_mm5`  in  1  mm5 op is MEM_FILL.
- `pipe_id_mm5`  in  ID_W  fill entry id at mm5.
- `pipe_complete_mm5`  in  1  fill done.
- `pipe_recycle_mm5`  in  1  fill must retry.

## Operation
- Per-entry FSM: IDLE → REQ_MEM (alloc) → PDG_MEM (mem_gnt while selected) → REQ_PIPE (mem_rsp to id) → PDG_PIPE (pipe_gnt while selected) → IDLE (complete) or WAIT (recycle) → REQ_PIPE (backoff expired).
- PDG_PIPE: complete has priority over recycle if both are asserted.
- WAIT: counter loads RECYCLE_DLY on entry and decrements each cycle. The entry exits when the counter reads 0, so WAIT lasts RECYCLE_DLY+1 cycles.
- Allocation picks the lowest-index IDLE entry. Paddr is latched on alloc. An entry freed in the same cycle is not eligible until the next cycle.
- Mem arbitration picks the first REQ_MEM entry at or after `mem_ptr`, wrapping modulo NUM_ENTRIES. Pipe arbitration uses the same scheme on its own `pipe_ptr`.
- Request stability: while `mem_req_valid & ~mem_gnt`, the selected id and addr are held even if lower-priority entries become ready. The same rule applies to the pipe request.
- On grant, the corresponding pointer moves to selected id + 1 (wrapping).
- `mem_rsp` and mm5 actions apply only to an entry in PDG_MEM or PDG_PIPE respectively; anything else is ignored.
- Full and alloc: `alloc_valid_mm5 & full` without a merge is illegal.

## Timing
- While reset is high, all outputs are 0. The cycle after reset deasserts, all entries are IDLE and both pointers are 0.
- Alloc in cycle N: `mem_req_valid` can assert in N+1.
- `mem_gnt` in N: entry is in PDG_MEM in N+1.
- `mem_rsp` in N: `pipe_req_mm0` in N+1.
- Complete in N: entry is IDLE in N+1 and allocatable in N+1. `full`/`num_valid` update in N+1.
- Alloc and complete in the same cycle: `num_valid` is unchanged.
- Reset mid-operation discards all entries; pending responses are then ignored.

## Configuration
- `FILLQ_ADDR_MERGE_EN` defined: an alloc whose `paddr[PADDR_W-1:LINE_BITS]` matches a non-IDLE entry that is not completing in the same cycle does not allocate. `alloc_merged_mm5`=1 and `alloc_id_mm5` returns that entry's id. Merge is legal when `full`.
- `FILLQ_ADDR_MERGE_EN` undefined: every alloc takes a new entry and `alloc_merged_mm5` is tied to 0. Duplicate lines can be outstanding.

## Test plan
- Reset, alloc 0x1000 → id 0. `mem_req_valid` next cycle with addr 0x1000; gnt; rsp id 0 → `pipe_req_mm0` next cycle; gnt; complete → `num_valid` back to 0.
- Fill all 4 entries → `full`=1, ids 0..3. Hold `mem_gnt`=0 for 3 cycles → `mem_req_id` stays 0. Then grant every cycle → grant order 0,1,2,3.
- Recycle at mm5 with RECYCLE_DLY=3 → `pipe_req_mm0` reasserts exactly 5 cycles after the recycle cycle.
- Merge on: alloc 0x2000, then alloc 0x2038 → `alloc_merged_mm5`=1, id 0, `num_valid`=1. Merge off: same stimulus → id 1, `num_valid`=2.
- Entry 2 completes while alloc arrives at full → complete honored; alloc illegal, assertion fires. Next cycle alloc → id 2.
- Assert reset while entries are in PDG_MEM and WAIT → all outputs 0. After release, `num_valid`=0 and a stale `mem_rsp` for id 1 has no effect.

Source files
------------

// File: rtl/fillq_bank.sv
// fillq_bank: a bank of NUM_ENTRIES outstanding cache-line fills between the mem pipe and memory.
// Optional feature: define FILLQ_ADDR_MERGE_EN to merge secondary misses into an outstanding entry for the same line.

module fillq_bank #(
  parameter int NUM_ENTRIES = 4,
  parameter int PADDR_W     = 40,
  parameter int LINE_BITS   = 6,
  parameter int RECYCLE_DLY = 3,
  parameter int ID_W        = $clog2(NUM_ENTRIES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               alloc_valid_mm5,
  input  logic [PADDR_W-1:0] alloc_paddr_mm5,
  output logic [ID_W-1:0]    alloc_id_mm5,
  output logic               alloc_merged_mm5,
  output logic               full,
  output logic [ID_W:0]      num_valid,
  output logic               mem_req_valid,
  output logic [ID_W-1:0]    mem_req_id,
  output logic [PADDR_W-1:0] mem_req_addr,
  input  logic               mem_gnt,
  input  logic               mem_rsp_valid,
  input  logic [ID_W-1:0]    mem_rsp_id,
  output logic               pipe_req_mm0,
  output logic [ID_W-1:0]    pipe_req_id_mm0,
  output logic [PADDR_W-1:0] pipe_req_addr_mm0,
  input  logic               pipe_gnt_mm0,
  input  logic               pipe_valid_mm5,
  input  logic               pipe_is_fill_mm5,
  input  logic [ID_W-1:0]    pipe_id_mm5,
  input  logic               pipe_complete_mm5,
  input  logic               pipe_recycle_mm5
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_MEM,
    S_PDG_MEM,
    S_REQ_PIPE,
    S_PDG_PIPE,
    S_WAIT
  } state_e;

  state_e             state_q [NUM_ENTRIES];
  logic [PADDR_W-1:0] paddr_q [NUM_ENTRIES];
  logic [3:0]         wait_q  [NUM_ENTRIES];
  logic [ID_W-1:0]    memPtr_q, pipePtr_q, memHoldId_q, pipeHoldId_q;
  logic               memHold_q, pipeHold_q;

  logic               mm5Act;
  logic               freeFound, mergeHit, allocTake;
  logic [ID_W-1:0]    freeId, mergeId;
  logic               memSelValid, pipeSelValid, memFire, pipeFire;
  logic [ID_W-1:0]    memSelId, pipeSelId;
  logic [ID_W:0]      cnt;

  function automatic logic [ID_W-1:0] wrapAdd(input logic [ID_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NUM_ENTRIES) sum = sum - NUM_ENTRIES;
    return ID_W'(sum);
  endfunction

  assign mm5Act = pipe_valid_mm5 & pipe_is_fill_mm5;

  // Entries freed this cycle still read IDLE-less here, so they only become allocatable next cycle.
  always_comb begin
    freeFound = 1'b0;
    freeId    = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (state_q[i] == S_IDLE) begin
        freeFound = 1'b1;
        freeId    = ID_W'(i);
      end
    end
  end

  always_comb begin
    mergeHit = 1'b0;
    mergeId  = '0;
`ifdef FILLQ_ADDR_MERGE_EN
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (state_q[i] != S_IDLE &&
          !(state_q[i] == S_PDG_PIPE && mm5Act && pipe_complete_mm5 && pipe_id_mm5 == ID_W'(i)) &&
          paddr_q[i][PADDR_W-1:LINE_BITS] == alloc_paddr_mm5[PADDR_W-1:LINE_BITS]) begin
        mergeHit = 1'b1;
        mergeId  = ID_W'(i);
      end
    end
`endif
  end

  assign allocTake = alloc_valid_mm5 & ~mergeHit & freeFound;

  // A stalled request keeps its id until granted, regardless of what else became ready.
  always_comb begin
    memSelValid = 1'b0;
    memSelId    = '0;
    if (memHold_q) begin
      memSelValid = 1'b1;
      memSelId    = memHoldId_q;
    end else begin
      for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
        if (state_q[wrapAdd(memPtr_q, k)] == S_REQ_MEM) begin
          memSelValid = 1'b1;
          memSelId    = wrapAdd(memPtr_q, k);
        end
      end
    end
  end

  always_comb begin
    pipeSelValid = 1'b0;
    pipeSelId    = '0;
    if (pipeHold_q) begin
      pipeSelValid = 1'b1;
      pipeSelId    = pipeHoldId_q;
    end else begin
      for (int k = NUM_ENTRIES - 1; k >= 0; k--) begin
        if (state_q[wrapAdd(pipePtr_q, k)] == S_REQ_PIPE) begin
          pipeSelValid = 1'b1;
          pipeSelId    = wrapAdd(pipePtr_q, k);
        end
      end
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (state_q[i] != S_IDLE) cnt = cnt + (ID_W+1)'(1);
    end
  end

  assign memFire  = memSelValid & mem_gnt;
  assign pipeFire = pipeSelValid & pipe_gnt_mm0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= S_IDLE;
        paddr_q[i] <= '0;
        wait_q[i]  <= '0;
      end
      memPtr_q     <= '0;
      pipePtr_q    <= '0;
      memHold_q    <= 1'b0;
      pipeHold_q   <= 1'b0;
      memHoldId_q  <= '0;
      pipeHoldId_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        case (state_q[i])
          S_IDLE: begin
            if (allocTake && freeId == ID_W'(i)) begin
              state_q[i] <= S_REQ_MEM;
              paddr_q[i] <= alloc_paddr_mm5;
            end
          end
          S_REQ_MEM: begin
            if (memFire && memSelId == ID_W'(i)) state_q[i] <= S_PDG_MEM;
          end
          S_PDG_MEM: begin
            if (mem_rsp_valid && mem_rsp_id == ID_W'(i)) state_q[i] <= S_REQ_PIPE;
          end
          S_REQ_PIPE: begin
            if (pipeFire && pipeSelId == ID_W'(i)) state_q[i] <= S_PDG_PIPE;
          end
          S_PDG_PIPE: begin
            if (mm5Act && pipe_id_mm5 == ID_W'(i)) begin
              if (pipe_complete_mm5) begin
                state_q[i] <= S_IDLE;
              end else if (pipe_recycle_mm5) begin
                state_q[i] <= S_WAIT;
                wait_q[i]  <= 4'(RECYCLE_DLY);
              end
            end
          end
          S_WAIT: begin
            if (wait_q[i] == 4'd0) state_q[i] <= S_REQ_PIPE;
            else                   wait_q[i]  <= wait_q[i] - 4'd1;
          end
          default: state_q[i] <= S_IDLE;
        endcase
      end
      if (memFire)  memPtr_q  <= wrapAdd(memSelId, 1);
      if (pipeFire) pipePtr_q <= wrapAdd(pipeSelId, 1);
      memHold_q    <= memSelValid & ~mem_gnt;
      memHoldId_q  <= memSelId;
      pipeHold_q   <= pipeSelValid & ~pipe_gnt_mm0;
      pipeHoldId_q <= pipeSelId;
    end
  end

  assign alloc_id_mm5      = reset ? '0 : (mergeHit ? mergeId : freeId);
  assign alloc_merged_mm5  = ~reset & alloc_valid_mm5 & mergeHit;
  assign num_valid         = reset ? '0 : cnt;
  assign full              = ~reset & (cnt == (ID_W+1)'(NUM_ENTRIES));
  assign mem_req_valid     = ~reset & memSelValid;
  assign mem_req_id        = mem_req_valid ? memSelId : '0;
  assign mem_req_addr      = mem_req_valid ? paddr_q[memSelId] : '0;
  assign pipe_req_mm0      = ~reset & pipeSelValid;
  assign pipe_req_id_mm0   = pipe_req_mm0 ? pipeSelId : '0;
  assign pipe_req_addr_mm0 = pipe_req_mm0 ? paddr_q[pipeSelId] : '0;

  // Allocating into a full bank is only legal when the request merges.
  assert property (@(posedge clk) disable iff (reset)
                   !(alloc_valid_mm5 && full && !alloc_merged_mm5));

endmodule

// File: tb/tb_fillq_bank.sv
// tb_fillq_bank: directed and randomized checking of fillq_bank against a behavioural fill-queue model.
// Honours FILLQ_ADDR_MERGE_EN the same way the design does.

module tb_fillq_bank;

  localparam int NE = 4;
  localparam int PW = 40;
  localparam int LB = 6;
  localparam int RD = 3;
  localparam int IW = 2;

  localparam int M_FREE      = 0;
  localparam int M_WANT_MEM  = 1;
  localparam int M_AT_MEM    = 2;
  localparam int M_WANT_PIPE = 3;
  localparam int M_IN_PIPE   = 4;
  localparam int M_BACKOFF   = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          alloc_valid_mm5 = 1'b0;
  logic [PW-1:0] alloc_paddr_mm5 = '0;
  logic [IW-1:0] alloc_id_mm5;
  logic          alloc_merged_mm5;
  logic          full;
  logic [IW:0]   num_valid;
  logic          mem_req_valid;
  logic [IW-1:0] mem_req_id;
  logic [PW-1:0] mem_req_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rsp_valid = 1'b0;
  logic [IW-1:0] mem_rsp_id = '0;
  logic          pipe_req_mm0;
  logic [IW-1:0] pipe_req_id_mm0;
  logic [PW-1:0] pipe_req_addr_mm0;
  logic          pipe_gnt_mm0 = 1'b0;
  logic          pipe_valid_mm5 = 1'b0;
  logic          pipe_is_fill_mm5 = 1'b0;
  logic [IW-1:0] pipe_id_mm5 = '0;
  logic          pipe_complete_mm5 = 1'b0;
  logic          pipe_recycle_mm5 = 1'b0;

  int compared = 0;
  int mismatched = 0;

  // Model state: one phase per entry plus the two arbiters.
  int            ph [NE];
  logic [PW-1:0] addr [NE];
  int            backoffLeft [NE];
  int            memPtr = 0, pipePtr = 0, memHeldId = 0, pipeHeldId = 0;
  bit            memHeld = 0, pipeHeld = 0;

  typedef struct {
    bit            allocMerged;
    int            allocId;
    bit            full;
    int            numValid;
    bit            memV;
    int            memId;
    logic [PW-1:0] memAddr;
    bit            pipeV;
    int            pipeId;
    logic [PW-1:0] pipeAddr;
  } exp_t;

  fillq_bank #(
    .NUM_ENTRIES(NE), .PADDR_W(PW), .LINE_BITS(LB), .RECYCLE_DLY(RD)
  ) dut (
    .clk(clk), .reset(reset),
    .alloc_valid_mm5(alloc_valid_mm5), .alloc_paddr_mm5(alloc_paddr_mm5),
    .alloc_id_mm5(alloc_id_mm5), .alloc_merged_mm5(alloc_merged_mm5),
    .full(full), .num_valid(num_valid),
    .mem_req_valid(mem_req_valid), .mem_req_id(mem_req_id), .mem_req_addr(mem_req_addr),
    .mem_gnt(mem_gnt), .mem_rsp_valid(mem_rsp_valid), .mem_rsp_id(mem_rsp_id),
    .pipe_req_mm0(pipe_req_mm0), .pipe_req_id_mm0(pipe_req_id_mm0),
    .pipe_req_addr_mm0(pipe_req_addr_mm0), .pipe_gnt_mm0(pipe_gnt_mm0),
    .pipe_valid_mm5(pipe_valid_mm5), .pipe_is_fill_mm5(pipe_is_fill_mm5),
    .pipe_id_mm5(pipe_id_mm5), .pipe_complete_mm5(pipe_complete_mm5),
    .pipe_recycle_mm5(pipe_recycle_mm5)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit completingNow(input int i);
    return pipe_valid_mm5 && pipe_is_fill_mm5 && pipe_complete_mm5 &&
           int'(pipe_id_mm5) == i && ph[i] == M_IN_PIPE;
  endfunction

  function automatic exp_t modelExpect();
    exp_t e;
    bit   found;
    int   i;
    e = '{default: 0};
    found = 0;
    for (int j = 0; j < NE; j++) begin
      if (ph[j] != M_FREE) e.numValid++;
      if (!found && ph[j] == M_FREE) begin
        found = 1;
        e.allocId = j;
      end
    end
    e.full = (e.numValid == NE);
`ifdef FILLQ_ADDR_MERGE_EN
    for (int j = 0; j < NE; j++) begin
      if (!e.allocMerged && alloc_valid_mm5 && ph[j] != M_FREE && !completingNow(j) &&
          (addr[j] >> LB) == (alloc_paddr_mm5 >> LB)) begin
        e.allocMerged = 1;
        e.allocId = j;
      end
    end
`endif
    if (memHeld) begin
      e.memV = 1;
      e.memId = memHeldId;
    end else begin
      for (int k = 0; k < NE; k++) begin
        i = (memPtr + k) % NE;
        if (!e.memV && ph[i] == M_WANT_MEM) begin
          e.memV = 1;
          e.memId = i;
        end
      end
    end
    if (pipeHeld) begin
      e.pipeV = 1;
      e.pipeId = pipeHeldId;
    end else begin
      for (int k = 0; k < NE; k++) begin
        i = (pipePtr + k) % NE;
        if (!e.pipeV && ph[i] == M_WANT_PIPE) begin
          e.pipeV = 1;
          e.pipeId = i;
        end
      end
    end
    if (e.memV)  e.memAddr  = addr[e.memId];
    if (e.pipeV) e.pipeAddr = addr[e.pipeId];
    return e;
  endfunction

  task automatic modelStep();
    exp_t e;
    int   oldPh [NE];
    if (reset) begin
      for (int j = 0; j < NE; j++) begin
        ph[j] = M_FREE;
        backoffLeft[j] = 0;
      end
      memPtr = 0; pipePtr = 0; memHeld = 0; pipeHeld = 0;
      return;
    end
    e = modelExpect();
    oldPh = ph;
    if (alloc_valid_mm5 && !e.allocMerged) begin
      ph[e.allocId] = M_WANT_MEM;
      addr[e.allocId] = alloc_paddr_mm5;
    end
    memHeld = e.memV && !mem_gnt;
    memHeldId = e.memId;
    if (e.memV && mem_gnt) begin
      ph[e.memId] = M_AT_MEM;
      memPtr = (e.memId + 1) % NE;
    end
    pipeHeld = e.pipeV && !pipe_gnt_mm0;
    pipeHeldId = e.pipeId;
    if (e.pipeV && pipe_gnt_mm0) begin
      ph[e.pipeId] = M_IN_PIPE;
      pipePtr = (e.pipeId + 1) % NE;
    end
    if (mem_rsp_valid && oldPh[mem_rsp_id] == M_AT_MEM) ph[mem_rsp_id] = M_WANT_PIPE;
    if (pipe_valid_mm5 && pipe_is_fill_mm5 && oldPh[pipe_id_mm5] == M_IN_PIPE) begin
      if (pipe_complete_mm5) begin
        ph[pipe_id_mm5] = M_FREE;
      end else if (pipe_recycle_mm5) begin
        ph[pipe_id_mm5] = M_BACKOFF;
        backoffLeft[pipe_id_mm5] = RD + 1;
      end
    end
    for (int j = 0; j < NE; j++) begin
      if (oldPh[j] == M_BACKOFF) begin
        backoffLeft[j]--;
        if (backoffLeft[j] == 0) ph[j] = M_WANT_PIPE;
      end
    end
  endtask

  initial begin
    for (int j = 0; j < NE; j++) begin
      ph[j] = M_FREE;
      addr[j] = '0;
      backoffLeft[j] = 0;
    end
    forever begin
      @(posedge clk);
      modelStep();
    end
  end

  // Single compare process: every cycle, every output against the model (zeros under reset).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        checkOutput("rst mem_req_valid", 64'(mem_req_valid), 64'(0));
        checkOutput("rst pipe_req_mm0", 64'(pipe_req_mm0), 64'(0));
        checkOutput("rst num_valid", 64'(num_valid), 64'(0));
        checkOutput("rst full", 64'(full), 64'(0));
        checkOutput("rst alloc_merged", 64'(alloc_merged_mm5), 64'(0));
        checkOutput("rst alloc_id", 64'(alloc_id_mm5), 64'(0));
        checkOutput("rst mem_req_addr", 64'(mem_req_addr), 64'(0));
        checkOutput("rst pipe_req_addr", 64'(pipe_req_addr_mm0), 64'(0));
      end else begin
        e = modelExpect();
        checkOutput("model num_valid", 64'(num_valid), 64'(e.numValid));
        checkOutput("model full", 64'(full), 64'(e.full));
        checkOutput("model alloc_merged", 64'(alloc_merged_mm5), 64'(e.allocMerged));
        checkOutput("model mem_req_valid", 64'(mem_req_valid), 64'(e.memV));
        checkOutput("model pipe_req_mm0", 64'(pipe_req_mm0), 64'(e.pipeV));
        if (alloc_valid_mm5) checkOutput("model alloc_id", 64'(alloc_id_mm5), 64'(e.allocId));
        if (e.memV) begin
          checkOutput("model mem_req_id", 64'(mem_req_id), 64'(e.memId));
          checkOutput("model mem_req_addr", 64'(mem_req_addr), 64'(e.memAddr));
        end
        if (e.pipeV) begin
          checkOutput("model pipe_req_id", 64'(pipe_req_id_mm0), 64'(e.pipeId));
          checkOutput("model pipe_req_addr", 64'(pipe_req_addr_mm0), 64'(e.pipeAddr));
        end
      end
    end
  end

  task automatic clearInputs();
    alloc_valid_mm5 = 0; alloc_paddr_mm5 = '0; mem_gnt = 0; mem_rsp_valid = 0;
    mem_rsp_id = '0; pipe_gnt_mm0 = 0; pipe_valid_mm5 = 0; pipe_is_fill_mm5 = 0;
    pipe_id_mm5 = '0; pipe_complete_mm5 = 0; pipe_recycle_mm5 = 0;
  endtask

  // One cycle of inputs driven just after the edge; returns at the following negedge.
  task automatic applyStimulus(input bit av, input logic [PW-1:0] pa, input bit mg,
                               input bit rv, input int rid, input bit pg,
                               input bit pv, input int pid, input bit pc, input bit pr);
    @(posedge clk);
    #1;
    reset = 0;
    alloc_valid_mm5 = av; alloc_paddr_mm5 = pa; mem_gnt = mg;
    mem_rsp_valid = rv; mem_rsp_id = IW'(rid); pipe_gnt_mm0 = pg;
    pipe_valid_mm5 = pv; pipe_is_fill_mm5 = pv; pipe_id_mm5 = IW'(pid);
    pipe_complete_mm5 = pc; pipe_recycle_mm5 = pr;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(0, '0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    reset = 1;
    clearInputs();
    @(negedge clk);
    checkOutput("in-reset mem_req_valid", 64'(mem_req_valid), 64'(0));
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    checkOutput("post-reset num_valid", 64'(num_valid), 64'(0));
    checkOutput("post-reset full", 64'(full), 64'(0));
  endtask

  task automatic randomCycle();
    exp_t e;
    @(posedge clk);
    #1;
    reset = ($urandom_range(0, 299) == 0);
    mem_gnt = 1'($urandom_range(0, 1));
    mem_rsp_valid = ($urandom_range(0, 2) == 0);
    mem_rsp_id = IW'($urandom_range(0, NE - 1));
    pipe_gnt_mm0 = 1'($urandom_range(0, 1));
    pipe_valid_mm5 = ($urandom_range(0, 2) == 0);
    pipe_is_fill_mm5 = ($urandom_range(0, 4) != 0);
    pipe_id_mm5 = IW'($urandom_range(0, NE - 1));
    pipe_complete_mm5 = 1'($urandom_range(0, 1));
    pipe_recycle_mm5 = 1'($urandom_range(0, 1));
    alloc_paddr_mm5 = PW'(32'h1000 + ($urandom_range(0, 5) << LB) + $urandom_range(0, 63));
    alloc_valid_mm5 = ($urandom_range(0, 4) < 2);
    if (alloc_valid_mm5) begin
      e = modelExpect();
      if (e.full && !e.allocMerged) alloc_valid_mm5 = 0;
    end
  endtask

  initial begin
    clearInputs();
    repeat (2) @(posedge clk);
    doReset();

    // Single line end to end.
    applyStimulus(1, 40'h1000, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("basic alloc_id", 64'(alloc_id_mm5), 64'(0));
    checkOutput("basic no mem_req yet", 64'(mem_req_valid), 64'(0));
    applyStimulus(0, '0, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("basic mem_req_valid", 64'(mem_req_valid), 64'(1));
    checkOutput("basic mem_req_addr", 64'(mem_req_addr), 64'h1000);
    checkOutput("basic num_valid 1", 64'(num_valid), 64'(1));
    applyStimulus(0, '0, 0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("basic mem_req dropped", 64'(mem_req_valid), 64'(0));
    applyStimulus(0, '0, 0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("basic pipe_req", 64'(pipe_req_mm0), 64'(1));
    checkOutput("basic pipe_req_addr", 64'(pipe_req_addr_mm0), 64'h1000);
    applyStimulus(0, '0, 0, 0, 0, 0, 1, 0, 1, 0);
    checkOutput("basic pipe_req dropped", 64'(pipe_req_mm0), 64'(0));
    idleCycle();
    checkOutput("basic num_valid 0", 64'(num_valid), 64'(0));

    // Fill the bank, stall memory, then grant in round-robin order.
    doReset();
    for (int i = 0; i < NE; i++) begin
      applyStimulus(1, PW'(32'h3000 + i * 32'h100), 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("fill alloc_id", 64'(alloc_id_mm5), 64'(i));
    end
    for (int i = 0; i < 3; i++) begin
      idleCycle();
      checkOutput("fill full", 64'(full), 64'(1));
      checkOutput("stall mem_req_id", 64'(mem_req_id), 64'(0));
    end
    for (int i = 0; i < NE; i++) begin
      applyStimulus(0, '0, 1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("mem grant order", 64'(mem_req_id), 64'(i));
    end
    for (int i = 0; i < NE; i++) applyStimulus(0, '0, 0, 1, i, 0, 0, 0, 0, 0);
    for (int i = 0; i < NE; i++) begin
      applyStimulus(0, '0, 0, 0, 0, 1, 0, 0, 0, 0);
      checkOutput("pipe grant order", 64'(pipe_req_id_mm0), 64'(i));
    end
    applyStimulus(0, '0, 0, 0, 0, 0, 1, 2, 1, 0);
    checkOutput("full while completing", 64'(full), 64'(1));
    applyStimulus(1, 40'h5000, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("realloc freed id", 64'(alloc_id_mm5), 64'(2));
    checkOutput("freed not full", 64'(full), 64'(0));
    idleCycle();
    checkOutput("refilled num_valid", 64'(num_valid), 64'(4));

    // Recycle backoff: the pipe request comes back exactly 5 cycles later.
    doReset();
    applyStimulus(1, 40'h7000, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, '0, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, '0, 0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, '0, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, '0, 0, 0, 0, 0, 1, 0, 0, 1);
    for (int k = 1; k <= 5; k++) begin
      idleCycle();
      checkOutput("recycle pipe_req", 64'(pipe_req_mm0), 64'(k == 5));
    end

    // Secondary miss to the same line.
    doReset();
    applyStimulus(1, 40'h2000, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("merge first id", 64'(alloc_id_mm5), 64'(0));
    applyStimulus(1, 40'h2038, 0, 0, 0, 0, 0, 0, 0, 0);
`ifdef FILLQ_ADDR_MERGE_EN
    checkOutput("merge merged", 64'(alloc_merged_mm5), 64'(1));
    checkOutput("merge id", 64'(alloc_id_mm5), 64'(0));
    idleCycle();
    checkOutput("merge num_valid", 64'(num_valid), 64'(1));
`else
    checkOutput("merge merged", 64'(alloc_merged_mm5), 64'(0));
    checkOutput("merge id", 64'(alloc_id_mm5), 64'(1));
    idleCycle();
    checkOutput("merge num_valid", 64'(num_valid), 64'(2));
`endif

    // Reset with one entry in PDG_MEM and one in WAIT; a stale response afterwards is ignored.
    doReset();
    applyStimulus(1, 40'h8000, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 40'h9000, 1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, '0, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("second grant id", 64'(mem_req_id), 64'(1));
    applyStimulus(0, '0, 0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, '0, 0, 0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, '0, 0, 0, 0, 0, 1, 0, 0, 1);
    idleCycle();
    checkOutput("pre-reset num_valid", 64'(num_valid), 64'(2));
    @(posedge clk);
    #1;
    reset = 1;
    clearInputs();
    @(negedge clk);
    checkOutput("mid-op reset num_valid", 64'(num_valid), 64'(0));
    checkOutput("mid-op reset pipe_req", 64'(pipe_req_mm0), 64'(0));
    applyStimulus(0, '0, 0, 1, 1, 0, 0, 0, 0, 0);
    checkOutput("after reset num_valid", 64'(num_valid), 64'(0));
    idleCycle();
    checkOutput("stale rsp pipe_req", 64'(pipe_req_mm0), 64'(0));
    checkOutput("stale rsp num_valid", 64'(num_valid), 64'(0));

    // Randomized traffic against the model.
    doReset();
    for (int c = 0; c < 3000; c++) randomCycle();
    @(posedge clk);
    #1;
    reset = 0;
    clearInputs();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
